// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: multi-cycle mult/div, mthi/mtlo, optional
// multiply-accumulate (codes 7-10) enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   pend, pend_n;
    logic          wr, wr_n;
    logic [31:0]   hi_n, lo_n;

    logic is_mul, is_div, is_mthi, is_mtlo;
    logic is_madd, is_msub, mul_signed;

    always_comb begin
        is_mthi = (md_op == OP_MTHI);
        is_mtlo = (md_op == OP_MTLO);
        is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_madd = (md_op == OP_MADD) || (md_op == OP_MADDU);
        is_msub = (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`else
        is_madd = 1'b0;
        is_msub = 1'b0;
`endif
        is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU) || is_madd || is_msub;
        mul_signed = (md_op == OP_MULT) || (md_op == OP_MADD)
                  || (md_op == OP_MSUB);
    end

    // Products: operands extended to 64 bits, result kept modulo 2^64
    logic [63:0] a_ext, b_ext, prod, acc, mul_res;

    always_comb begin
        a_ext   = mul_signed ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext   = mul_signed ? {{32{B[31]}}, B} : {32'd0, B};
        prod    = a_ext * b_ext;
        acc     = {hi, lo};
        mul_res = prod;
        if (is_madd) mul_res = acc + prod;
        if (is_msub) mul_res = acc - prod;
    end

    // Signed division on magnitudes avoids the INT_MIN / -1 overflow case
    logic        div_signed;
    logic [31:0] dvs, a_mag, b_mag, q_mag, r_mag, quo, rem;

    always_comb begin
        div_signed = (md_op == OP_DIV);
        dvs   = (B == 32'd0) ? 32'd1 : B;
        a_mag = (div_signed && A[31]) ? (32'd0 - A) : A;
        b_mag = (div_signed && dvs[31]) ? (32'd0 - dvs) : dvs;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quo   = (div_signed && (A[31] ^ dvs[31])) ? (32'd0 - q_mag) : q_mag;
        rem   = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    logic accept;

    always_comb begin
        accept  = start && !flush && (state == S_IDLE)
               && (is_mul || is_div || is_mthi || is_mtlo);
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        wr_n    = wr;
        hi_n    = hi;
        lo_n    = lo;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_mthi: hi_n = A;
                        is_mtlo: lo_n = A;
                        is_mul: begin
                            pend_n  = mul_res;
                            wr_n    = 1'b1;
                            cnt_n   = CW'(MULT_CYCLES);
                            state_n = S_BUSY;
                        end
                        is_div: begin
                            pend_n  = {rem, quo};
                            wr_n    = (B != 32'd0);
                            cnt_n   = CW'(DIV_CYCLES);
                            state_n = S_BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    cnt_n   = '0;
                    wr_n    = 1'b0;
                    state_n = S_IDLE;
                    if (wr) begin
                        hi_n = pend[63:32];
                        lo_n = pend[31:0];
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= '0;
            wr    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            wr    <= wr_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign busy = (state == S_BUSY);

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against an arithmetic HI/LO model.
// Follows MDU_MADD_EN to decide whether codes 7-10 are live.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
        .A(A), .B(B), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit op_valid(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd6) || (MADD && op >= 4'd7 && op <= 4'd10);
    endfunction

    function automatic int op_lat(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return MC;
        if (op == 4'd3 || op == 4'd4) return DC;
        if (MADD && op >= 4'd7 && op <= 4'd10) return MC;
        return 0;
    endfunction

    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, acc, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {m_hi, m_lo};
        res = acc;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            4'd4: if (b != 0) begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                res = {r[31:0], q[31:0]};
            end
            4'd5: res = {a, m_lo};
            4'd6: res = {m_hi, a};
            4'd7: if (MADD) res = acc + 64'(sa * sb);
            4'd8: if (MADD) res = acc + ua * ub;
            4'd9: if (MADD) res = acc - 64'(sa * sb);
            4'd10: if (MADD) res = acc - ua * ub;
            default: ;
        endcase
        m_hi = res[63:32];
        m_lo = res[31:0];
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit fl,
                          input bit poke, input string tag);
        int n;
        int exp_n;
        bit acc;
        acc   = !fl && op_valid(op);
        exp_n = acc ? op_lat(op) : 0;
        if (acc) model(op, a, b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        flush = fl;
        @(negedge clk);
        start = poke && (exp_n > 0);
        md_op = 4'd1;
        A     = $urandom;
        B     = $urandom;
        flush = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            start = 1'b0;
            A = $urandom;
            B = $urandom;
        end
        start = 1'b0;
        check({tag, "_busy"}, 64'(n), 64'(exp_n));
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "mult");
        run_op(4'd4, 32'd7, 32'd2, 1'b0, 1'b1, "divu_poke");
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_flush");
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div");
        run_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "mthi");
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        run_op(4'd4, 32'd99, 32'd0, 1'b0, 1'b0, "divu_z");
        run_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0, "mthi0");
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "mtlo");
        run_op(4'd8, 32'd1, 32'd1, 1'b0, 1'b0, "maddu");
        run_op(4'd13, 32'd5, 32'd5, 1'b0, 1'b0, "op13");

        // reset in the third busy cycle of a mult
        @(negedge clk);
        start = 1'b1; md_op = 4'd1; A = 32'd9; B = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_late_hi", 64'(hi), 64'd0);
        check("arst_late_lo", 64'(lo), 64'd0);
        run_op(4'd6, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 300; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(),
                   ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                   "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy length of mult/multu/madd/maddu/msub/msubu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy length of div/divu.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: an E-stage HI/LO instruction is presented this cycle.
REQ-006 SHALL have port md_op, input, 4: operation code.
- 0 none; 1 mult; 2 multu; 3 div; 4 divu; 5 mthi; 6 mtlo.
- 7 madd; 8 maddu; 9 msub; 10 msubu.
- 11-15 none.
REQ-007 SHALL have port A, input, 32: rs operand.
REQ-008 SHALL have port B, input, 32: rt operand.
REQ-009 SHALL have port flush, input, 1: the E-stage instruction is cancelled by an exception or interrupt.
REQ-010 SHALL have port busy, output, 1: registered; a multi-cycle operation is in progress.
REQ-011 SHALL have port hi, output, 32: architectural HI register.
REQ-012 SHALL have port lo, output, 32: architectural LO register.

Function
REQ-013 SHALL accept an op at a clock edge only if start=1, flush=0, busy=0 and md_op is a valid code; otherwise the edge SHALL change no state.
REQ-014 SHALL compute the result from A and B at acceptance and hold it in an internal 64-bit pending register; later A/B changes SHALL have no effect.
REQ-015 SHALL, on an accepted multi-cycle op, load a counter with MULT_CYCLES or DIV_CYCLES and set busy=1 at that edge.
REQ-016 SHALL decrement the counter at each later edge; at the edge where it equals 1, SHALL write {hi,lo} from the pending register, clear the counter and set busy=0.
REQ-017 SHALL therefore hold busy=1 for exactly N cycles after the accept edge; hi/lo SHALL be visible from the first cycle with busy=0.
REQ-018 SHALL execute mthi (hi<=A) and mtlo (lo<=A) at the accept edge, with no busy cycle.
REQ-019 mult SHALL produce {hi,lo} = signed 64-bit A*B; multu SHALL produce the unsigned 64-bit product.
REQ-020 div SHALL give lo = signed quotient truncated toward zero and hi = remainder with the sign of A; divu SHALL give the unsigned quotient and remainder.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-022 div/divu with B=0 SHALL still run DIV_CYCLES busy cycles and SHALL leave hi/lo unchanged at completion.
REQ-023 SHALL ignore start while busy=1 (the pipeline stalls such instructions in D); the running op SHALL be unaffected.
REQ-024 flush SHALL only suppress acceptance in its own cycle; an op already accepted SHALL complete normally.
REQ-025 SHALL add or subtract 64-bit results modulo 2^64 and SHALL raise no overflow indication.

Reset
REQ-026 SHALL, on reset_n=0, immediately and without a clock edge, force hi=0, lo=0, busy=0, counter=0 and pending=0.
REQ-027 SHALL abandon any in-flight op on reset assertion; hi/lo SHALL NOT be written by it afterwards.
REQ-028 SHALL accept a new op at the first rising edge on which reset_n=1.

Configuration
REQ-029 SHALL, when macro MDU_MADD_EN is defined, implement codes 7-10 with MULT_CYCLES latency:
- madd: {hi,lo} += signed A*B.
- maddu: {hi,lo} += unsigned A*B.
- msub: {hi,lo} -= signed A*B.
- msubu: {hi,lo} -= unsigned A*B.
- The accumulate SHALL use the {hi,lo} value at the accept edge.
REQ-030 SHALL, when MDU_MADD_EN is undefined, treat codes 7-10 as none: no busy, no hi/lo write.

Verification
REQ-031 mult A=0xFFFFFFFE, B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 divu A=7, B=2, then start with mult during busy -> busy high 10 cycles; then lo=3, hi=1; the mult is ignored.
REQ-033 div A=-7, B=2 with flush=1 in the start cycle -> busy stays 0; hi/lo unchanged. Same op without flush -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 mthi A=0x12345678 -> hi=0x12345678 at the next edge; busy never rises.
REQ-035 reset_n pulled low in the 3rd busy cycle of mult -> hi=lo=0 and busy=0 at once; no later write of the mult result.
REQ-036 With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu A=1, B=1 -> hi=1, lo=0 after 5 cycles. Without the macro: no change and no busy.
